// File: rtl/ctrl_pkg.sv
// Shared types for the accumulator softcore control unit: FSM states,
// one-hot instruction indices and ALU operation codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        ERR    = 3'd7
    } state_e;

    localparam int INSN_ADD  = 0;
    localparam int INSN_SUB  = 1;
    localparam int INSN_AND  = 2;
    localparam int INSN_OR   = 3;
    localparam int INSN_XOR  = 4;
    localparam int INSN_SHL  = 5;
    localparam int INSN_SHR  = 6;
    localparam int INSN_ADDI = 7;
    localparam int INSN_LD   = 8;
    localparam int INSN_ST   = 9;
    localparam int INSN_MVA  = 10;
    localparam int INSN_MVR  = 11;
    localparam int INSN_BEQZ = 12;
    localparam int INSN_JMP  = 13;
    localparam int INSN_NOP  = 14;
    localparam int INSN_HALT = 15;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_SHR = 4'd6;

    // Maps the register-register ALU class bits to an ALU code; ADDI and
    // address generation fall through to ADD.
    function automatic logic [3:0] alu_code(input logic [6:0] ops);
        logic [3:0] code;
        code = ALU_ADD;
        if (ops[INSN_SUB])      code = ALU_SUB;
        else if (ops[INSN_AND]) code = ALU_AND;
        else if (ops[INSN_OR])  code = ALU_OR;
        else if (ops[INSN_XOR]) code = ALU_XOR;
        else if (ops[INSN_SHL]) code = ALU_SHL;
        else if (ops[INSN_SHR]) code = ALU_SHR;
        return code;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Memory port handshake: the control unit requests with mem_read/mem_write,
// the memory completes the access in any cycle it drives mem_ready high.
interface multicycle_control_if;
    logic mem_read;
    logic mem_write;
    logic mem_ready;

    modport master (output mem_read, output mem_write, input mem_ready);
    modport slave  (input mem_read, input mem_write, output mem_ready);
endinterface

// File: rtl/ctrl_wait_timer.sv
// Saturating wait-cycle counter with synchronous clear and a compare
// against the configured timeout.
module ctrl_wait_timer #(
    parameter int MAX_COUNT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic timeout
);
    localparam int W = $clog2(MAX_COUNT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != W'(MAX_COUNT)))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign timeout = (cnt_q == W'(MAX_COUNT));
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the accumulator softcore: FETCH/DECODE/EXEC/MEM/WB
// with memory timeout, illegal-encoding trap and absorbing HALT/ERR states.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int INSN_COUNT  = 16,
    parameter int ALU_MODE_W  = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INSN_COUNT-1:0]  insn_en,
    input  logic                   acc_zero,
    multicycle_control_if.master   mem,
    output logic [ALU_MODE_W-1:0]  alu_mode,
    output logic                   pc_sel,
    output logic                   pc_write_en,
    output logic                   ir_load,
    output logic                   acc_write_en,
    output logic                   reg_write_en,
    output logic                   alu_a_sel,
    output logic                   alu_b_sel,
    output logic                   busy,
    output logic                   illegal,
    output logic                   bus_err,
    output state_e                 dbg_state
);
    state_e                state_q, state_d;
    logic [INSN_COUNT-1:0] cls_q, cls_d;
    logic                  pc_sel_q, pc_sel_d;
    logic                  illegal_q, illegal_d;
    logic                  bus_err_q, bus_err_d;
    logic                  wait_inc, wait_timeout;
    logic                  mem_read_o, mem_write_o;

    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        pc_sel_d     = pc_sel_q;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        wait_inc     = 1'b0;
        alu_mode     = '0;
        pc_sel       = 1'b0;
        pc_write_en  = 1'b0;
        ir_load      = 1'b0;
        acc_write_en = 1'b0;
        reg_write_en = 1'b0;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_read_o = 1'b1;
                if (mem.mem_ready) begin
                    ir_load = 1'b1;
                    state_d = DECODE;
                end else if (wait_timeout) begin
                    state_d   = ERR;
                    bus_err_d = 1'b1;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            DECODE: begin
                cls_d = insn_en;
                if ($countones(insn_en) != 1) begin
                    state_d   = ERR;
                    illegal_d = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = WB;
                if ((|cls_q[INSN_SHR:INSN_ADD]) || cls_q[INSN_ADDI]) begin
                    alu_mode     = ALU_MODE_W'(alu_code(cls_q[INSN_SHR:INSN_ADD]));
                    alu_b_sel    = cls_q[INSN_ADDI];
                    acc_write_en = 1'b1;
                end else if (cls_q[INSN_MVR]) begin
                    acc_write_en = 1'b1;
                end else if (cls_q[INSN_MVA]) begin
                    reg_write_en = 1'b1;
                end else if (cls_q[INSN_LD] || cls_q[INSN_ST]) begin
                    alu_b_sel = 1'b1;
                    state_d   = MEM;
                end else if (cls_q[INSN_BEQZ]) begin
                    pc_sel = acc_zero;
                end else if (cls_q[INSN_JMP]) begin
                    pc_sel = 1'b1;
                end else if (cls_q[INSN_HALT]) begin
                    state_d = HALT;
                end else if (cls_q[INSN_NOP]) begin
                    state_d = WB;
                end
                // WB replays the branch decision made here
                pc_sel_d = pc_sel;
            end
            MEM: begin
                // Only LD and ST reach MEM, so the class is one of the two
                if (cls_q[INSN_LD]) begin
                    mem_read_o   = 1'b1;
                    acc_write_en = mem.mem_ready;
                end else begin
                    mem_write_o = 1'b1;
                end
                if (mem.mem_ready) begin
                    state_d = WB;
                end else if (wait_timeout) begin
                    state_d   = ERR;
                    bus_err_d = 1'b1;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            WB: begin
                pc_write_en = 1'b1;
                pc_sel      = pc_sel_q;
                state_d     = FETCH;
            end
            HALT: state_d = HALT;
            ERR:  state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cls_q     <= '0;
            pc_sel_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            pc_sel_q  <= pc_sel_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    ctrl_wait_timer #(.MAX_COUNT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_d != state_q),
        .inc     (wait_inc),
        .timeout (wait_timeout)
    );

    assign mem.mem_read  = mem_read_o;
    assign mem.mem_write = mem_write_o;
    assign busy          = (state_q != IDLE) && (state_q != HALT) && (state_q != ERR);
    assign illegal       = illegal_q;
    assign bus_err       = bus_err_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected strobe vectors
// are queued with the mem_ready value to drive, then drained and compared.
module tb_multicycle_control;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] insn_en = '0;
    logic        acc_zero = 1'b0;
    logic [3:0]  alu_mode;
    logic        pc_sel, pc_write_en, ir_load, acc_write_en, reg_write_en;
    logic        alu_a_sel, alu_b_sel, busy, illegal, bus_err;
    state_e      dbg_state;

    multicycle_control_if mem_bus();

    multicycle_control #(.INSN_COUNT(16), .ALU_MODE_W(4), .MEM_TIMEOUT(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .insn_en      (insn_en),
        .acc_zero     (acc_zero),
        .mem          (mem_bus.master),
        .alu_mode     (alu_mode),
        .pc_sel       (pc_sel),
        .pc_write_en  (pc_write_en),
        .ir_load      (ir_load),
        .acc_write_en (acc_write_en),
        .reg_write_en (reg_write_en),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .busy         (busy),
        .illegal      (illegal),
        .bus_err      (bus_err),
        .dbg_state    (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Strobe vector layout: {alu_mode[3:0], busy, ir_load, mem_read, mem_write,
    //                        acc_we, reg_we, pc_we, pc_sel, alu_b_sel}
    localparam logic [8:0] V_FRDY  = 9'h1C0;
    localparam logic [8:0] V_FWAIT = 9'h140;
    localparam logic [8:0] V_BUSY  = 9'h100;
    localparam logic [8:0] V_NONE  = 9'h000;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [12:0] exp_q[$];
    logic        rdy_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] obs();
        return {alu_mode, busy, ir_load, mem_bus.mem_read, mem_bus.mem_write,
                acc_write_en, reg_write_en, pc_write_en, pc_sel, alu_b_sel};
    endfunction

    // Driver tasks
    task automatic push(input logic [3:0] mode, input logic [8:0] bits, input logic rdy, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({mode, bits});
            rdy_q.push_back(rdy);
        end
    endtask

    task automatic drain(input string tag);
        int          i;
        logic [12:0] e;
        i = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            mem_bus.mem_ready = rdy_q.pop_front();
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, i), 32'(obs()), 32'(e));
            check($sformatf("%s_asel[%0d]", tag, i), 32'(alu_a_sel), 32'd0);
            i++;
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        mem_bus.mem_ready = 1'b0;
        insn_en = '0;
        acc_zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_strobes"}, 32'(obs()), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
        check({tag, "_flags"}, 32'({illegal, bus_err}), 32'd0);
        rst_n = 1'b1;
    endtask

    // FETCH, DECODE, EXEC, WB, next FETCH for the single-pass classes
    task automatic run_simple(input string tag, input logic [15:0] insn,
                              input logic [12:0] exec_v, input logic [8:0] wb_v);
        do_reset({tag, "_rst"});
        insn_en = insn;
        push(4'd0, V_FRDY, 1'b1, 1);
        push(4'd0, V_BUSY, 1'b1, 1);
        push(exec_v[12:9], exec_v[8:0], 1'b1, 1);
        push(4'd0, wb_v, 1'b1, 1);
        push(4'd0, V_FRDY, 1'b1, 1);
        drain(tag);
    endtask

    initial begin
        // Register-class instructions and moves
        run_simple("add",  16'h0001, {4'd0, 9'h110}, 9'h104);
        run_simple("sub",  16'h0002, {4'd1, 9'h110}, 9'h104);
        run_simple("shr",  16'h0040, {4'd6, 9'h110}, 9'h104);
        run_simple("addi", 16'h0080, {4'd0, 9'h111}, 9'h104);
        run_simple("mva",  16'h0400, {4'd0, 9'h108}, 9'h104);
        run_simple("mvr",  16'h0800, {4'd0, 9'h110}, 9'h104);
        run_simple("jmp",  16'h2000, {4'd0, 9'h102}, 9'h106);
        run_simple("nop",  16'h4000, {4'd0, 9'h100}, 9'h104);

        // Branch both ways; acc_zero is set after the reset inside run_simple
        fork
            begin
                @(posedge rst_n);
                acc_zero = 1'b1;
            end
            run_simple("beqz_t", 16'h1000, {4'd0, 9'h102}, 9'h106);
        join
        run_simple("beqz_f", 16'h1000, {4'd0, 9'h100}, 9'h104);

        // LD with three wait cycles in MEM
        do_reset("ld_rst");
        insn_en = 16'h0100;
        push(4'd0, V_FRDY, 1'b1, 1);
        push(4'd0, V_BUSY, 1'b1, 1);
        push(4'd0, 9'h101, 1'b1, 1);
        push(4'd0, 9'h140, 1'b0, 3);
        push(4'd0, 9'h150, 1'b1, 1);
        push(4'd0, 9'h104, 1'b1, 1);
        push(4'd0, V_FRDY, 1'b1, 1);
        drain("ld");

        // Non-one-hot encoding traps into ERR
        do_reset("ill_rst");
        insn_en = 16'h0003;
        push(4'd0, V_FRDY, 1'b1, 1);
        push(4'd0, V_BUSY, 1'b1, 1);
        push(4'd0, V_NONE, 1'b1, 5);
        drain("ill");
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_buserr", 32'(bus_err), 32'd0);
        check("ill_state", 32'(dbg_state), 32'(ERR));
        do_reset("ill_clr");

        // FETCH timeout: 16 waiting cycles, then ERR with bus_err
        do_reset("to_rst");
        insn_en = 16'h4000;
        push(4'd0, V_FWAIT, 1'b0, 16);
        drain("to_wait");
        check("to_pre_err", 32'(bus_err), 32'd0);
        check("to_pre_state", 32'(dbg_state), 32'(FETCH));
        push(4'd0, V_NONE, 1'b0, 3);
        drain("to_err");
        check("to_buserr", 32'(bus_err), 32'd1);
        check("to_state", 32'(dbg_state), 32'(ERR));

        // Ready arriving on the 16th cycle wins over the timeout
        do_reset("tw_rst");
        insn_en = 16'h4000;
        push(4'd0, V_FWAIT, 1'b0, 15);
        push(4'd0, V_FRDY, 1'b1, 1);
        push(4'd0, V_BUSY, 1'b1, 1);
        push(4'd0, V_BUSY, 1'b1, 1);
        drain("tw");
        check("tw_buserr", 32'(bus_err), 32'd0);

        // HALT is absorbing
        do_reset("halt_rst");
        insn_en = 16'h8000;
        push(4'd0, V_FRDY, 1'b1, 1);
        push(4'd0, V_BUSY, 1'b1, 2);
        push(4'd0, V_NONE, 1'b1, 100);
        drain("halt");
        check("halt_state", 32'(dbg_state), 32'(HALT));

        // Reset during a ST memory wait drops mem_write immediately
        do_reset("st_rst");
        insn_en = 16'h0200;
        push(4'd0, V_FRDY, 1'b1, 1);
        push(4'd0, V_BUSY, 1'b1, 1);
        push(4'd0, 9'h101, 1'b1, 1);
        push(4'd0, 9'h120, 1'b0, 2);
        drain("st");
        @(posedge clk);
        #2;
        check("st_pre_wr", 32'(mem_bus.mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("st_abort_wr", 32'(mem_bus.mem_write), 32'd0);
        check("st_abort_vec", 32'(obs()), 32'd0);
        check("st_abort_state", 32'(dbg_state), 32'(IDLE));
        do_reset("st_rerst");
        insn_en = 16'h4000;
        push(4'd0, V_FRDY, 1'b1, 1);
        push(4'd0, V_BUSY, 1'b1, 1);
        drain("st_restart");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
